// File: rtl/result_drain_if.sv
// result_drain_if: write side from pe_array (rounded row-pairs) and the
// packed result stream leaving the accelerator. The drain uses the slave
// modport; whoever feeds it and consumes its result uses the master modport.
interface result_drain_if #(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int DW          = 16,
  parameter int ROWS_PER_WR = 2
);
  localparam int PW = $clog2(ROWS / ROWS_PER_WR);

  logic                          wr_valid_i;
  logic [PW-1:0]                 wr_pair_i;
  logic [ROWS_PER_WR*COLS*DW-1:0] wr_data_i;
  logic                          wr_ready_o;
  logic                          result_valid_o;
  logic [2*DW-1:0]               result_payload_o;
  logic                          drain_done_o;

  modport master (
    output wr_valid_i, wr_pair_i, wr_data_i,
    input  wr_ready_o, result_valid_o, result_payload_o, drain_done_o
  );

  modport slave (
    input  wr_valid_i, wr_pair_i, wr_data_i,
    output wr_ready_o, result_valid_o, result_payload_o, drain_done_o
  );
endinterface

// File: rtl/result_drain.sv
// result_drain: collects pe_array row-pairs into a ROWSxCOLS buffer and,
// once every pair has been written, streams the matrix out two elements
// per word in row-major order with no back-pressure.
// Optional feature macro: RESULT_DRAIN_RELU_EN (ReLU applied to each element
// as it is drained; the stored buffer is identical in both builds).
module result_drain #(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int DW          = 16,
  parameter int ROWS_PER_WR = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  result_drain_if.slave   bus
);

  localparam int ELEMS      = ROWS * COLS;
  localparam int WORDS      = ELEMS / 2;
  localparam int PAIRS      = ROWS / ROWS_PER_WR;
  localparam int PAIR_ELEMS = ROWS_PER_WR * COLS;
  localparam int EW         = $clog2(ELEMS);
  localparam int KW         = $clog2(WORDS);
  localparam int OW         = $clog2(PAIR_ELEMS);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state, state_next;
  logic [PAIRS-1:0] fill_mask, fill_mask_next;
  logic [KW-1:0]   k, k_next;
  logic            out_valid, out_valid_next;
  logic [2*DW-1:0] out_payload, out_payload_next;
  logic            out_done, out_done_next;
  logic            ready, ready_next;

  logic [DW-1:0]   mem [ELEMS];

  logic            accept;
  logic [KW-1:0]   rd_k;
  logic [EW-1:0]   rd_idx_lo, rd_idx_hi;
  logic [DW-1:0]   elem_lo, elem_hi;
  logic [2*DW-1:0] rd_word;

  assign accept = (state == FILL) && bus.wr_valid_i;

  // Buffer write: a whole row-pair lands in one cycle; never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < PAIR_ELEMS; i++) begin
        mem[{bus.wr_pair_i, OW'(i)}] <= bus.wr_data_i[i*DW +: DW];
      end
    end
  end

  // Fetch the word to register next; forwards the pair being written this
  // cycle so the first word of a drain can come from the completing write.
  always_comb begin
    rd_k      = (state == DRAIN) ? k + KW'(1) : '0;
    rd_idx_lo = {rd_k, 1'b0};
    rd_idx_hi = {rd_k, 1'b1};
    elem_lo   = mem[rd_idx_lo];
    elem_hi   = mem[rd_idx_hi];
    if (accept && (rd_idx_lo[EW-1:OW] == bus.wr_pair_i)) begin
      elem_lo = bus.wr_data_i[int'(rd_idx_lo[OW-1:0])*DW +: DW];
    end
    if (accept && (rd_idx_hi[EW-1:OW] == bus.wr_pair_i)) begin
      elem_hi = bus.wr_data_i[int'(rd_idx_hi[OW-1:0])*DW +: DW];
    end
`ifdef RESULT_DRAIN_RELU_EN
    if (elem_lo[DW-1]) begin
      elem_lo = '0;
    end
    if (elem_hi[DW-1]) begin
      elem_hi = '0;
    end
`endif
    rd_word = {elem_hi, elem_lo};
  end

  // Next-state and next-output logic; outputs are all registered below.
  always_comb begin
    state_next       = state;
    fill_mask_next   = fill_mask;
    k_next           = k;
    out_valid_next   = 1'b0;
    out_payload_next = out_payload;
    out_done_next    = 1'b0;
    ready_next       = 1'b1;
    case (state)
      FILL: begin
        if (accept) begin
          fill_mask_next = fill_mask | (PAIRS'(1) << bus.wr_pair_i);
          if (&fill_mask_next) begin
            state_next       = DRAIN;
            k_next           = '0;
            out_valid_next   = 1'b1;
            out_payload_next = rd_word;
            ready_next       = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (k == KW'(WORDS - 1)) begin
          state_next     = FILL;
          fill_mask_next = '0;
          k_next         = '0;
        end else begin
          k_next           = k + KW'(1);
          out_valid_next   = 1'b1;
          out_payload_next = rd_word;
          out_done_next    = (k_next == KW'(WORDS - 1));
          ready_next       = 1'b0;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= FILL;
      fill_mask   <= '0;
      k           <= '0;
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_done    <= 1'b0;
      ready       <= 1'b1;
    end else begin
      state       <= state_next;
      fill_mask   <= fill_mask_next;
      k           <= k_next;
      out_valid   <= out_valid_next;
      out_payload <= out_payload_next;
      out_done    <= out_done_next;
      ready       <= ready_next;
    end
  end

  assign bus.wr_ready_o       = ready;
  assign bus.result_valid_o   = out_valid;
  assign bus.result_payload_o = out_payload;
  assign bus.drain_done_o     = out_done;

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: randomized fill/drain traffic against a matrix-level
// reference model; expected words are queued when a matrix completes and a
// monitor pops them whenever the drain presents a word.
// Honours RESULT_DRAIN_RELU_EN the same way as the design.
module tb_result_drain;

  localparam int ROWS   = 16;
  localparam int COLS   = 16;
  localparam int DW     = 16;
  localparam int RPW    = 2;
  localparam int NELEM  = ROWS * COLS;
  localparam int NWORDS = NELEM / 2;
  localparam int PELEMS = RPW * COLS;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  result_drain_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ROWS_PER_WR(RPW)) bus ();

  result_drain #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ROWS_PER_WR(RPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        done;
    int          k;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_mem [NELEM];
  bit   [7:0]  model_mask = '0;
  int          drain_left = 0;
  logic [31:0] hold_exp = '0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  bit          first_en = 0;
  logic [31:0] first_expect = '0;
  bit          last_en = 0;
  logic [31:0] last_expect = '0;
  bit          gap_en = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] reluModel(input logic [15:0] v);
`ifdef RESULT_DRAIN_RELU_EN
    return ($signed(v) < 0) ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic pushMatrix();
    for (int kk = 0; kk < NWORDS; kk++) begin
      sb.push_back('{word: {reluModel(model_mem[2*kk+1]), reluModel(model_mem[2*kk])},
                     done: (kk == NWORDS - 1), k: kk});
    end
  endtask

  // Reference model: a matrix is complete once every pair has been seen;
  // then 128 cycles of drain during which writes are dropped.
  always @(posedge clk) begin
    if (rst_n) begin
      sb.delete();
      drain_left = 0;
      model_mask = '0;
      hold_exp   = '0;
    end else if (drain_left > 0) begin
      drain_left--;
    end else if (bus.wr_valid_i) begin
      for (int j = 0; j < PELEMS; j++) begin
        model_mem[int'(bus.wr_pair_i)*PELEMS + j] = bus.wr_data_i[j*16 +: 16];
      end
      model_mask[bus.wr_pair_i] = 1'b1;
      if (model_mask == 8'hFF) begin
        pushMatrix();
        drain_left = NWORDS;
        model_mask = '0;
      end
    end
  end

  // Monitor: compares the DUT output against the scoreboard every cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    checkOutput("wr_ready", 32'(bus.wr_ready_o), 32'(drain_left == 0));
    checkOutput("result_valid", 32'(bus.result_valid_o), 32'(drain_left > 0));
    if (bus.result_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_word", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("payload", bus.result_payload_o, e.word);
        checkOutput("drain_done", 32'(bus.drain_done_o), 32'(e.done));
        hold_exp = e.word;
        if (e.k == 0 && first_en) begin
          checkOutput("first_word", bus.result_payload_o, first_expect);
          first_en = 0;
        end
        if (e.k == 0 && gap_en) begin
          checkOutput("restart_gap", 32'(cyc - done_cyc), 32'd9);
          gap_en = 0;
        end
        if (e.k == NWORDS - 1 && last_en) begin
          checkOutput("last_word", bus.result_payload_o, last_expect);
          last_en = 0;
        end
        if (e.done) begin
          done_cyc = cyc;
        end
      end
    end else begin
      checkOutput("idle_done", 32'(bus.drain_done_o), 32'd0);
      checkOutput("hold_payload", bus.result_payload_o, hold_exp);
    end
  end

  task automatic applyStimulus(input bit v, input logic [2:0] p, input logic [511:0] d);
    bus.wr_valid_i = v;
    bus.wr_pair_i  = p;
    bus.wr_data_i  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 3'd0, '0);
    end
  endtask

  function automatic logic [511:0] seqData(input int p);
    logic [511:0] d;
    for (int j = 0; j < PELEMS; j++) begin
      d[j*16 +: 16] = 16'(p*PELEMS + j);
    end
    return d;
  endfunction

  function automatic logic [511:0] rndData();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) begin
      d[w*32 +: 32] = $urandom;
    end
    return d;
  endfunction

  function automatic logic [511:0] constData(input logic [15:0] c);
    logic [511:0] d;
    for (int j = 0; j < PELEMS; j++) begin
      d[j*16 +: 16] = c;
    end
    return d;
  endfunction

  task automatic fillRandom();
    for (int p = 0; p < 8; p++) begin
      applyStimulus(1'b1, 3'(p), rndData());
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (drain_left != 0 && n < 400) begin
      idle(1);
      n++;
    end
    checkOutput("drain_timeout", 32'(n < 400), 32'd1);
  endtask

  initial begin
    int order [9];
    logic [511:0] d;
    order = '{7, 3, 3, 0, 1, 2, 4, 5, 6};
    bus.wr_valid_i = 1'b0;
    bus.wr_pair_i  = '0;
    bus.wr_data_i  = '0;
    rst_n = 1'b1;
    idle(3);
    rst_n = 1'b0;
    idle(3);

    // Ordered fill, elem[i] = i.
    first_expect = 32'h0001_0000;
    first_en     = 1;
    last_expect  = 32'h00FF_00FE;
    last_en      = 1;
    for (int p = 0; p < 8; p++) begin
      applyStimulus(1'b1, 3'(p), seqData(p));
    end
    waitDrain();
    idle(2);

    // Out-of-order fill with a duplicate overwrite of pair 3.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 3'(order[i]), (i == 2) ? constData(16'hAAAA) : rndData());
    end
    waitDrain();
    idle(2);

    // Write attempted mid-drain, then a partial fill that must not drain.
    fillRandom();
    idle(20);
    applyStimulus(1'b1, 3'd0, constData(16'h1234));
    waitDrain();
    for (int p = 0; p < 7; p++) begin
      applyStimulus(1'b1, 3'(p), rndData());
    end
    idle(10);
    applyStimulus(1'b1, 3'd7, rndData());
    waitDrain();
    idle(2);

    // Reset while word 40 is on the output.
    fillRandom();
    idle(40);
    rst_n = 1'b1;
    idle(1);
    rst_n = 1'b0;
    idle(5);
    fillRandom();
    waitDrain();
    idle(2);

    // Negative element in word 0.
    d = rndData();
    d[31:0] = {16'h0005, 16'hFFFE};
`ifdef RESULT_DRAIN_RELU_EN
    first_expect = 32'h0005_0000;
`else
    first_expect = 32'h0005_FFFE;
`endif
    first_en = 1;
    applyStimulus(1'b1, 3'd0, d);
    for (int p = 1; p < 8; p++) begin
      applyStimulus(1'b1, 3'(p), rndData());
    end
    waitDrain();
    idle(2);

    // Back-to-back matrices with contiguous writes.
    fillRandom();
    waitDrain();
    gap_en = 1;
    fillRandom();
    waitDrain();
    checkOutput("gap_seen", 32'(gap_en), 32'd0);

    idle(5);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
